rr_resource_scheduler: RTL and testbench
========================================

Name: rr_resource_scheduler

Overview:
Round-robin scheduler that shares one multi-cycle resource, such as a bus or memory port, among N requesters. A grant is held while the owner keeps its request asserted. Ownership is bounded by a programmable quantum, and the owner is pre-empted when the quantum expires. The block sits between the requester agents and the shared resource's select mux. Fairness uses the modified round-robin pointer: after a release, the pointer moves to owner+1.

Parameters:
N, 8, number of requesters (N>=2)
QW, 8, width of the quantum field and of the ownership counter
M (localparam), $clog2(N), width of the owner index and of the pointer

Ports:
i_clk  input  1  scheduler clock
i_rstn  input  1  asynchronous active-low reset
i_req  input  N  request vector; the owner holds its bit high for the whole transaction
i_mask  input  N  per-requester disable (1 = excluded from arbitration, and forces release if it is the owner)
i_quantum  input  QW  maximum ownership cycles, sampled at grant; 0 = unlimited
o_gnt  output  N  registered one-hot grant
o_owner  output  M  index of the current owner; valid only while o_busy
o_busy  output  1  high while in OWN (equals |o_gnt)
o_timeout  output  1  one-cycle pulse when the owner is pre-empted by quantum expiry

Behaviour:
- Reset (async, i_rstn=0): state=IDLE, ptr=0, cnt=0, o_gnt=0, o_owner=0, o_busy=0, o_timeout=0. Reset mid-OWN drops the grant immediately.
- Effective request: ereq = i_req & ~i_mask.
- States: IDLE and OWN.
- IDLE:
  - If ereq==0, stay in IDLE.
  - Otherwise pick the winner w = first set bit of ereq at or above ptr, wrapping modulo N.
  - At the edge: o_gnt<=onehot(w), o_owner<=w, cnt<=i_quantum, state<=OWN.
  - Latency: ereq seen in IDLE cycle c gives o_gnt high from cycle c+1.
- OWN, evaluated each cycle, in priority order:
  1. Owner bit of ereq is 0 (dropped or masked): release. No timeout.
  2. cnt!=0 and cnt==1: release with o_timeout<=1.
  3. Otherwise, if cnt!=0 then cnt<=cnt-1. An unlimited quantum (cnt==0) never decrements.
- Quantum result: with i_quantum=Q>0, o_gnt is high for exactly Q cycles when the owner does not release earlier.
- Release edge: o_gnt<=0, o_busy<=0, state<=IDLE, ptr<=(owner==N-1)?0:owner+1. o_owner keeps its last value.
- Turnaround: there is always at least one cycle with o_gnt=0 between consecutive grants. Release is seen in cycle c, the next grant is visible no earlier than cycle c+2.
- o_timeout: registered, asserted only in the first cycle after the pre-emptive release, otherwise 0.
- Pre-empted requester still requesting:
  - It gets the lowest priority, because ptr has moved past it.
  - If it is the sole requester, it is re-granted after the one idle cycle, with a fresh quantum.
- Arbitration inputs: i_quantum and i_mask changes while in OWN do not affect cnt; they only matter at the next arbitration. The exception is the owner's own mask bit, which forces release.
- Requests arriving during OWN are ignored until IDLE. There is no queueing, and no request latching inside the block.
- All outputs are registered. There are no combinational input-to-output paths.

Decomposition:
- Package rr_sched_pkg holds:
  - the state enum sched_state_t {IDLE, OWN};
  - a pointer-increment helper function with wrap at N-1.
- Sub-module rr_sched_pick, purely combinational, with parameter N:
  - inputs: req[N], ptr[M];
  - outputs: onehot[N], idx[M], any.
  - Implemented by double-width rotate right, isolate lowest set bit, rotate left.
  - Instantiated once in the top.

Test Plan:
1. Reset, then i_req=8'b0000_0101, Q=4, requesters hold their requests -> grant 0 for 4 cycles with o_timeout pulse, 1 idle cycle, grant 2 for 4 cycles, then grant 0 again.
2. Q=0, i_req[3]=1 held 20 cycles, then dropped in cycle c -> o_gnt=8'h08 for 20 cycles, o_gnt=0 from c+1, o_timeout never asserted, ptr=4.
3. All 8 requesting with ptr=7 after the previous owner 6 -> grant order 7,0,1,...,6, each grant separated by exactly one idle cycle.
4. Owner 5 in OWN, i_mask[5] set in cycle c -> o_gnt=0 at c+1, o_timeout=0; a masked requester is never granted while its mask is set.
5. Q=1, i_req=8'h01 held -> o_gnt alternates 1-cycle on, 1-cycle off, with an o_timeout pulse on each off cycle.
6. i_rstn asserted mid-OWN with cnt=3 -> o_gnt, o_busy and o_timeout are 0 asynchronously; after release, arbitration restarts from ptr=0.

Source files
------------

// File: rtl/rr_sched_pkg.sv
// Shared types and helpers for the round-robin resource scheduler.
package rr_sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } sched_state_t;

   // Advances the round-robin pointer past the given index, wrapping at n-1.
   function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned n);
      return (p >= n - 1) ? 0 : p + 1;
   endfunction

endpackage

// File: rtl/rr_sched_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping.
module rr_sched_pick #(
   parameter int N = 8,
   localparam int M = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [M-1:0] ptr,
   output logic [N-1:0] onehot,
   output logic [M-1:0] idx,
   output logic         any
);

   logic [2*N-1:0] dbl_r;
   logic [2*N-1:0] dbl_l;
   logic [N-1:0]   rot;
   logic [N-1:0]   iso;

   // Rotate so ptr sits at bit 0, keep the lowest set bit, then rotate back.
   assign dbl_r  = {req, req} >> ptr;
   assign rot    = dbl_r[N-1:0];
   assign iso    = rot & (~rot + {{(N-1){1'b0}}, 1'b1});
   assign dbl_l  = {iso, iso} << ptr;
   assign onehot = dbl_l[2*N-1:N];
   assign any    = |req;

   always_comb begin
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (onehot[i]) idx = M'(i);
      end
   end

endmodule

// File: rtl/rr_resource_scheduler.sv
// Round-robin owner scheduler for one shared multi-cycle resource, with a
// per-grant ownership quantum and forced release on mask.
module rr_resource_scheduler
   import rr_sched_pkg::*;
#(
   parameter int N  = 8,
   parameter int QW = 8,
   localparam int M = $clog2(N)
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic [N-1:0]  i_req,
   input  logic [N-1:0]  i_mask,
   input  logic [QW-1:0] i_quantum,
   output logic [N-1:0]  o_gnt,
   output logic [M-1:0]  o_owner,
   output logic          o_busy,
   output logic          o_timeout
);

   sched_state_t  state_q, state_d;
   logic [M-1:0]  ptr_q, ptr_d;
   logic [QW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [M-1:0]  owner_q, owner_d;
   logic          busy_q, busy_d;
   logic          timeout_q, timeout_d;

   logic [N-1:0]  ereq;
   logic [N-1:0]  pick_onehot;
   logic [M-1:0]  pick_idx;
   logic          pick_any;
   logic          release_now;

   assign ereq = i_req & ~i_mask;

   rr_sched_pick #(.N(N)) u_pick (
      .req    (ereq),
      .ptr    (ptr_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      gnt_d       = gnt_q;
      owner_d     = owner_q;
      busy_d      = busy_q;
      timeout_d   = 1'b0;
      release_now = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_any) begin
               gnt_d   = pick_onehot;
               owner_d = pick_idx;
               cnt_d   = i_quantum;
               busy_d  = 1'b1;
               state_d = OWN;
            end
         end
         OWN: begin
            // A dropped or masked owner wins over quantum expiry: no timeout then.
            if (!ereq[owner_q]) begin
               release_now = 1'b1;
            end else if (cnt_q == QW'(1)) begin
               release_now = 1'b1;
               timeout_d   = 1'b1;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - QW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (release_now) begin
         gnt_d   = '0;
         busy_d  = 1'b0;
         state_d = IDLE;
         ptr_d   = M'(ptr_inc(int'(owner_q), N));
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         gnt_q     <= '0;
         owner_q   <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         owner_q   <= owner_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_gnt     = gnt_q;
   assign o_owner   = owner_q;
   assign o_busy    = busy_q;
   assign o_timeout = timeout_q;

endmodule

// File: tb/tb_rr_resource_scheduler.sv
// Directed bench for rr_resource_scheduler: per-cycle expectations go into a
// scoreboard queue and an independent monitor compares them after each edge.
module tb_rr_resource_scheduler;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] mask;
   logic [7:0] quantum;
   logic [7:0] gnt;
   logic [2:0] owner;
   logic       busy;
   logic       tmo;

   typedef struct {
      logic [7:0] gnt;
      logic       to;
      logic [2:0] own;
   } exp_t;

   exp_t       sbq[$];
   int         n_total = 0;
   int         n_pass  = 0;
   logic [2:0] last_owner = 3'd0;

   rr_resource_scheduler #(.N(8), .QW(8)) dut (
      .i_clk     (clk),
      .i_rstn    (rst_n),
      .i_req     (req),
      .i_mask    (mask),
      .i_quantum (quantum),
      .o_gnt     (gnt),
      .o_owner   (owner),
      .o_busy    (busy),
      .o_timeout (tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   function automatic logic [2:0] idx_of(input logic [7:0] oh);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
      return r;
   endfunction

   // Called at a negedge with inputs already set; expectation is for the next edge.
   task automatic tick(input logic [7:0] g, input logic t);
      exp_t e;
      if (g != 8'h00) last_owner = idx_of(g);
      e.gnt = g;
      e.to  = t;
      e.own = last_owner;
      sbq.push_back(e);
      @(negedge clk);
   endtask

   task automatic ticks(input int n, input logic [7:0] g, input logic t);
      for (int i = 0; i < n; i++) tick(g, t);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("gnt",     32'(gnt),   32'(e.gnt));
            chk("busy",    32'(busy),  32'(|e.gnt));
            chk("timeout", 32'(tmo),   32'(e.to));
            chk("owner",   32'(owner), 32'(e.own));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      rst_n   = 1'b0;
      req     = 8'h00;
      mask    = 8'h00;
      quantum = 8'd0;
      repeat (2) @(negedge clk);
      chk("rst_gnt",     32'(gnt),   32'h0);
      chk("rst_busy",    32'(busy),  32'h0);
      chk("rst_timeout", 32'(tmo),   32'h0);
      chk("rst_owner",   32'(owner), 32'h0);
      rst_n = 1'b1;
      tick(8'h00, 1'b0);

      // Two requesters, Q=4: 0 then 2 then 0 again, each pre-empted.
      req = 8'h05; quantum = 8'd4;
      ticks(4, 8'h01, 1'b0);
      tick(8'h00, 1'b1);
      ticks(4, 8'h04, 1'b0);
      tick(8'h00, 1'b1);
      tick(8'h01, 1'b0);
      req = 8'h00;
      tick(8'h00, 1'b0);
      tick(8'h00, 1'b0);

      // Unlimited quantum; mid-ownership Q/mask changes on others are ignored.
      req = 8'h08; quantum = 8'd0;
      ticks(5, 8'h08, 1'b0);
      quantum = 8'd1; mask = 8'h01;
      ticks(15, 8'h08, 1'b0);
      req = 8'h00; mask = 8'h00;
      tick(8'h00, 1'b0);

      // Pointer now 4: bit 5 must beat bit 0; then steer pointer to 7.
      req = 8'h21; quantum = 8'd2;
      ticks(2, 8'h20, 1'b0);
      tick(8'h00, 1'b1);
      req = 8'h41; quantum = 8'd1;
      tick(8'h40, 1'b0);
      tick(8'h00, 1'b1);

      // Everyone requests from ptr=7: order 7,0,1..6 with one idle cycle each.
      req = 8'hFF;
      tick(8'h80, 1'b0);
      tick(8'h00, 1'b1);
      for (int k = 0; k < 7; k++) begin
         tick(8'(1 << k), 1'b0);
         tick(8'h00, 1'b1);
      end
      req = 8'h00;
      tick(8'h00, 1'b0);

      // Owner 5 masked mid-ownership: silent release, never re-granted while masked.
      req = 8'h20; quantum = 8'd0;
      ticks(3, 8'h20, 1'b0);
      mask = 8'h20;
      tick(8'h00, 1'b0);
      ticks(3, 8'h00, 1'b0);
      req = 8'h21;
      tick(8'h01, 1'b0);
      req = 8'h00; mask = 8'h00;
      tick(8'h00, 1'b0);
      tick(8'h00, 1'b0);

      // Q=1 sole requester: one cycle on, one cycle off with a timeout pulse.
      req = 8'h01; quantum = 8'd1;
      for (int k = 0; k < 3; k++) begin
         tick(8'h01, 1'b0);
         tick(8'h00, 1'b1);
      end
      req = 8'h00;
      tick(8'h00, 1'b0);

      // Async reset with cnt=3, then arbitration restarts from ptr=0.
      req = 8'h01; quantum = 8'd5;
      ticks(3, 8'h01, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("arst_gnt",     32'(gnt),   32'h0);
      chk("arst_busy",    32'(busy),  32'h0);
      chk("arst_timeout", 32'(tmo),   32'h0);
      chk("arst_owner",   32'(owner), 32'h0);
      last_owner = 3'd0;
      @(negedge clk);
      rst_n = 1'b1;
      req = 8'h81; quantum = 8'd4;
      tick(8'h01, 1'b0);
      req = 8'h00;
      tick(8'h00, 1'b0);

      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
      chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
